// File: rtl/scmp_alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and op classification.
package scmp_alu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpDad  = 4'h1,
        OpRrl  = 4'h2,
        OpSr   = 4'h3,
        OpOr   = 4'h4,
        OpAnd  = 4'h5,
        OpXor  = 4'h6,
        OpInc  = 4'h7,
        OpDec  = 4'h8,
        OpMpy  = 4'h9,
        OpDiv  = 4'hA,
        OpPass = 4'hB
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_t;

    function automatic logic is_multi(alu_op_t op);
        return (op == OpMpy) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/scmp_alu_bcd_digit.sv
// One BCD digit adder: binary add, then +6 correction when the digit sum exceeds 9.
module scmp_alu_bcd_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] fixed;

    assign raw   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign fixed = raw + 5'd6;
    assign cout  = (raw > 5'd9);
    assign sum   = cout ? fixed[3:0] : raw[3:0];

endmodule

// File: rtl/scmp_seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, plus W-step shift-add multiply and
// restoring divide. All results are registered and change only on entry to DONE.
module scmp_seq_alu
    import scmp_alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  alu_op_t      op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cy_i,
    input  logic         ov_i,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res,
    output logic [W-1:0] res_hi,
    output logic         cy_o,
    output logic         ov_o
);

    localparam int unsigned ND = W / 4;
    localparam int unsigned CW = $clog2(W);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  b_q, lo_q, hi_q;
    logic          div_q, cy_q;

    // Decimal adder: ripple the digit carry from cy_i upward.
    logic [ND:0]  dc;
    logic [W-1:0] dad_sum;
    assign dc[0] = cy_i;

    for (genvar i = 0; i < ND; i++) begin : g_digit
        scmp_alu_bcd_digit u_digit (
            .a    (a[4*i +: 4]),
            .b    (b[4*i +: 4]),
            .cin  (dc[i]),
            .sum  (dad_sum[4*i +: 4]),
            .cout (dc[i+1])
        );
    end

    logic [W:0] add_full, inc_full, dec_full;
    assign add_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cy_i};
    assign inc_full = {1'b0, a} + {{W{1'b0}}, 1'b1};
    assign dec_full = {1'b0, a} - {{W{1'b0}}, 1'b1};

    logic [W-1:0] s_res;
    logic         s_cy, s_ov;

    always_comb begin
        s_res = a;
        s_cy  = cy_i;
        s_ov  = ov_i;
        case (op)
            OpAdd: begin
                s_res = add_full[W-1:0];
                s_cy  = add_full[W];
                s_ov  = (a[W-1] == b[W-1]) && (add_full[W-1] != a[W-1]);
            end
            OpDad: begin
                s_res = dad_sum;
                s_cy  = dc[ND];
            end
            OpRrl: begin
                s_res = {cy_i, a[W-1:1]};
                s_cy  = a[0];
            end
            OpSr:  s_res = {1'b0, a[W-1:1]};
            OpOr:  s_res = a | b;
            OpAnd: s_res = a & b;
            OpXor: s_res = a ^ b;
            OpInc: begin
                s_res = inc_full[W-1:0];
                s_cy  = inc_full[W];
            end
            OpDec: begin
                s_res = dec_full[W-1:0];
                s_cy  = dec_full[W];
            end
            default: s_res = a;
        endcase
    end

    // One iteration step; hi_q holds partial product / running remainder.
    logic [W:0]   mul_sum, div_sh, div_diff;
    logic [W-1:0] n_hi, n_lo;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    assign div_sh   = {hi_q, lo_q[W-1]};
    assign div_diff = div_sh - {1'b0, b_q};

    always_comb begin
        n_hi = mul_sum[W:1];
        n_lo = {mul_sum[0], lo_q[W-1:1]};
        if (div_q) begin
            if (!div_diff[W]) begin
                n_hi = div_diff[W-1:0];
                n_lo = {lo_q[W-2:0], 1'b1};
            end else begin
                n_hi = div_sh[W-1:0];
                n_lo = {lo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            cnt    <= '0;
            b_q    <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            div_q  <= 1'b0;
            cy_q   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            res    <= '0;
            res_hi <= '0;
            cy_o   <= 1'b0;
            ov_o   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (is_multi(op)) begin
                            state <= StIter;
                            cnt   <= CW'(W - 1);
                            b_q   <= b;
                            lo_q  <= a;
                            hi_q  <= '0;
                            div_q <= (op == OpDiv);
                            cy_q  <= cy_i;
                        end else begin
                            state  <= StDone;
                            done   <= 1'b1;
                            res    <= s_res;
                            res_hi <= '0;
                            cy_o   <= s_cy;
                            ov_o   <= s_ov;
                        end
                    end
                end
                StIter: begin
                    hi_q <= n_hi;
                    lo_q <= n_lo;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state  <= StDone;
                        done   <= 1'b1;
                        res    <= n_lo;
                        res_hi <= n_hi;
                        cy_o   <= cy_q;
                        ov_o   <= div_q && (b_q == '0);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_scmp_seq_alu.sv
// Directed scoreboard bench for scmp_seq_alu at W=8.
module tb_scmp_seq_alu;
    import scmp_alu_pkg::*;

    localparam int unsigned W = 8;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic       cy;
        logic       ov;
        int         lat;
        logic       chk_cy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    alu_op_t    op_s;
    logic [7:0] a_s, b_s;
    logic       cyi_s, ovi_s;
    logic       busy, done, cy_o, ov_o;
    logic [7:0] res, res_hi;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    scmp_seq_alu #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op_s),
        .a      (a_s),
        .b      (b_s),
        .cy_i   (cyi_s),
        .ov_i   (ovi_s),
        .busy   (busy),
        .done   (done),
        .res    (res),
        .res_hi (res_hi),
        .cy_o   (cy_o),
        .ov_o   (ov_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(logic [7:0] r, logic [7:0] h, logic c, logic v, int l, logic cc);
        exp_t e;
        e.res = r; e.hi = h; e.cy = c; e.ov = v; e.lat = l; e.chk_cy = cc;
        return e;
    endfunction

    function automatic exp_t model(alu_op_t o, logic [7:0] av, logic [7:0] bv, logic ci, logic vi);
        logic [8:0]  t;
        logic [15:0] p;
        logic [4:0]  s;
        logic        c;
        exp_t        e;
        e = mk(av, 8'h00, ci, vi, 1, 1'b1);
        case (o)
            OpAdd: begin
                t = {1'b0, av} + {1'b0, bv} + {8'h00, ci};
                e.res = t[7:0]; e.cy = t[8];
                e.ov = (av[7] == bv[7]) && (t[7] != av[7]);
            end
            OpDad: begin
                c = ci;
                for (int d = 0; d < 2; d++) begin
                    s = {1'b0, av[4*d +: 4]} + {1'b0, bv[4*d +: 4]} + {4'h0, c};
                    if (s > 5'd9) begin s = s + 5'd6; c = 1'b1; end
                    else c = 1'b0;
                    e.res[4*d +: 4] = s[3:0];
                end
                e.cy = c;
            end
            OpRrl: begin e.res = {ci, av[7:1]}; e.cy = av[0]; end
            OpSr:  e.res = av >> 1;
            OpOr:  e.res = av | bv;
            OpAnd: e.res = av & bv;
            OpXor: e.res = av ^ bv;
            OpInc: begin t = {1'b0, av} + 9'd1; e.res = t[7:0]; e.cy = t[8]; end
            OpDec: begin e.res = av - 8'd1; e.cy = (av == 8'h00); end
            OpMpy: begin
                p = 16'(av) * 16'(bv);
                e.res = p[7:0]; e.hi = p[15:8]; e.ov = 1'b0; e.lat = W + 1;
            end
            OpDiv: begin
                e.lat = W + 1; e.chk_cy = 1'b0;
                if (bv == 8'h00) begin e.res = 8'hFF; e.hi = av; e.ov = 1'b1; end
                else begin e.res = av / bv; e.hi = av % bv; e.ov = 1'b0; end
            end
            default: e.res = av;
        endcase
        return e;
    endfunction

    task automatic run(input alu_op_t o, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic vi, input exp_t e);
        exp_t g;
        int   n;
        logic busy_ok;
        string nm;
        nm = o.name();
        if (nm == "") nm = "undef";
        sb.push_back(e);
        @(negedge clk);
        op_s = o; a_s = av; b_s = bv; cyi_s = ci; ovi_s = vi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        busy_ok = busy;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            busy_ok &= busy;
        end
        g = sb.pop_front();
        check({nm, ".done"}, 32'(done), 32'd1);
        check({nm, ".latency"}, 32'(n), 32'(g.lat));
        check({nm, ".busy"}, 32'(busy_ok), 32'd1);
        check({nm, ".res"}, 32'(res), 32'(g.res));
        check({nm, ".res_hi"}, 32'(res_hi), 32'(g.hi));
        check({nm, ".ov_o"}, 32'(ov_o), 32'(g.ov));
        if (g.chk_cy) check({nm, ".cy_o"}, 32'(cy_o), 32'(g.cy));
        @(posedge clk); #1;
        check({nm, ".done_pulse"}, 32'(done), 32'd0);
        check({nm, ".res_hold"}, 32'(res), 32'(g.res));
    endtask

    task automatic run_m(input alu_op_t o, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic vi);
        run(o, av, bv, ci, vi, model(o, av, bv, ci, vi));
    endtask

    initial begin
        alu_op_t    ops[13];
        logic [7:0] ra, rb;
        int         pulses;

        ops = '{OpAdd, OpDad, OpRrl, OpSr, OpOr, OpAnd, OpXor, OpInc, OpDec,
                OpMpy, OpDiv, OpPass, alu_op_t'(4'hE)};
        rst = 1'b1; start = 1'b0; op_s = OpPass; a_s = '0; b_s = '0; cyi_s = 0; ovi_s = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.res", 32'(res), 32'd0);
        check("rst.res_hi", 32'(res_hi), 32'd0);
        check("rst.flags", 32'({cy_o, ov_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reference vectors with hand-computed results.
        run(OpAdd, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 8'h00, 1'b0, 1'b1, 1, 1'b1));
        run(OpDad, 8'h45, 8'h38, 1'b0, 1'b0, mk(8'h83, 8'h00, 1'b0, 1'b0, 1, 1'b1));
        run(OpDad, 8'h99, 8'h01, 1'b0, 1'b1, mk(8'h00, 8'h00, 1'b1, 1'b1, 1, 1'b1));
        run(OpMpy, 8'hFF, 8'hFF, 1'b0, 1'b1, mk(8'h01, 8'hFE, 1'b0, 1'b0, 9, 1'b1));
        run(OpDiv, 8'h64, 8'h07, 1'b0, 1'b0, mk(8'h0E, 8'h02, 1'b0, 1'b0, 9, 1'b0));
        run(OpDiv, 8'h64, 8'h00, 1'b0, 1'b0, mk(8'hFF, 8'h64, 1'b0, 1'b1, 9, 1'b0));
        run(OpRrl, 8'h81, 8'h00, 1'b1, 1'b0, mk(8'hC0, 8'h00, 1'b1, 1'b0, 1, 1'b1));
        run(OpDec, 8'h00, 8'h00, 1'b0, 1'b1, mk(8'hFF, 8'h00, 1'b1, 1'b1, 1, 1'b1));

        // Model-driven sweep across every op, including an undefined code.
        for (int pass = 0; pass < 2; pass++) begin
            foreach (ops[k]) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                if (ops[k] == OpDad) begin
                    ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                end
                run_m(ops[k], ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        run_m(OpDiv, 8'h05, 8'h09, 1'b0, 1'b0);
        run_m(OpMpy, 8'hA5, 8'h3C, 1'b1, 1'b1);

        // Abort an MPY with reset; an intervening start must be ignored.
        @(negedge clk);
        op_s = OpMpy; a_s = 8'hFF; b_s = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        op_s = OpAdd; a_s = 8'h01; b_s = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort.busy_mid", 32'(busy), 32'd1);
        check("abort.ignored_add", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.res", 32'(res), 32'd0);
        check("abort.res_hi", 32'(res_hi), 32'd0);
        check("abort.flags", 32'({cy_o, ov_o}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort.no_partial", 32'(pulses), 32'd0);
        run(OpInc, 8'hFF, 8'h00, 1'b0, 1'b0, mk(8'h00, 8'h00, 1'b1, 1'b0, 1, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
